// File: rtl/perf_counter_bank_pkg.sv
// Shared definitions for the performance counter bank: default sizing,
// per-event increment and the channel index enumeration.
package perf_counter_bank_pkg;

  localparam int PERF_NUM_CNT = 5;
  localparam int PERF_CNT_LEN = 64;
  localparam int PERF_CNT_INC = 1;
  localparam int PERF_XLEN    = 32;

  typedef enum logic [2:0] {
    p_CYCLE = 3'd0,
    p_INSTR = 3'd1,
    p_FLUSH = 3'd2,
    p_WAIT  = 3'd3,
    p_DECOD = 3'd4
  } perf_idx_e;

  // Index width that stays legal for a single-channel bank.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/perf_counter.sv
// Single performance counter channel: CNT_W-bit counter with increment,
// half-word write (write beats increment) and wrap detection.
module perf_counter
  import perf_counter_bank_pkg::*;
#(
  parameter int CNT_W = PERF_CNT_LEN,
  parameter int XLEN  = PERF_XLEN,
  parameter int INC   = PERF_CNT_INC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_en,
  input  logic             wr_lo,
  input  logic             wr_hi,
  input  logic [XLEN-1:0]  wr_data,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap
);

  localparam int HI_W = CNT_W - XLEN;

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic [CNT_W:0]   sum_s;
  logic             wrap_s;

  // Next counter value; a write discards a same-cycle increment and its wrap.
  always_comb begin
    sum_s      = {1'b0, cnt_r} + (CNT_W+1)'(INC);
    cnt_next_s = cnt_r;
    wrap_s     = 1'b0;
    if (wr_lo) begin
      cnt_next_s = {cnt_r[CNT_W-1:XLEN], wr_data};
    end else if (wr_hi) begin
      cnt_next_s = {wr_data[HI_W-1:0], cnt_r[XLEN-1:0]};
    end else if (inc_en) begin
      cnt_next_s = sum_s[CNT_W-1:0];
      wrap_s     = sum_s[CNT_W];
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // Counter state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_next_s;
    end
  end

  assign cnt  = cnt_r;
  assign wrap = wrap_s;

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of NUM_CNT performance counters with inhibit mask, half-word
// write port and a torn-free lo-then-hi read path through a shadow register.
// Optional feature macro PERF_CNT_OVF_IRQ_EN: sticky overflow flags and
// overflow interrupt; when undefined ovf_o and irq_o are tied low.
module perf_counter_bank
  import perf_counter_bank_pkg::*;
#(
  parameter int NUM_CNT = PERF_NUM_CNT,
  parameter int CNT_W   = PERF_CNT_LEN,
  parameter int XLEN    = PERF_XLEN,
  parameter int INC     = PERF_CNT_INC,
  localparam int IDX_W  = idx_width(NUM_CNT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_CNT-1:0] evt_i,
  input  logic               inh_wr_i,
  input  logic [NUM_CNT-1:0] inh_data_i,
  output logic [NUM_CNT-1:0] inh_o,
  input  logic               wr_en_i,
  input  logic [IDX_W-1:0]   wr_idx_i,
  input  logic               wr_hi_i,
  input  logic [XLEN-1:0]    wr_data_i,
  input  logic               rd_en_i,
  input  logic [IDX_W-1:0]   rd_idx_i,
  input  logic               rd_hi_i,
  output logic [XLEN-1:0]    rd_data_o,
  output logic               rd_valid_o,
  output logic [NUM_CNT-1:0] ovf_o,
  input  logic [NUM_CNT-1:0] ovf_clr_i,
  input  logic [NUM_CNT-1:0] ovf_irq_en_i,
  output logic               irq_o
);

  localparam int HI_W = CNT_W - XLEN;

  logic [CNT_W-1:0]   cnt_s [NUM_CNT];
  logic [NUM_CNT-1:0] wrap_s;
  logic [NUM_CNT-1:0] wr_sel_s;
  logic [NUM_CNT-1:0] inh_r;
  logic [CNT_W-1:0]   rd_cnt_s;
  logic               rd_in_range_s;
  logic [HI_W-1:0]    shadow_r;
  logic [XLEN-1:0]    rd_data_r;
  logic               rd_valid_r;

  // Write channel decode; out-of-range indices select nothing.
  always_comb begin
    wr_sel_s = {NUM_CNT{1'b0}};
    for (int n = 0; n < NUM_CNT; n++) begin
      wr_sel_s[n] = wr_en_i && (wr_idx_i == IDX_W'(n));
    end
  end

  for (genvar n = 0; n < NUM_CNT; n++) begin : g_ch
    perf_counter #(
      .CNT_W (CNT_W),
      .XLEN  (XLEN),
      .INC   (INC)
    ) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc_en  (evt_i[n] & ~inh_r[n]),
      .wr_lo   (wr_sel_s[n] & ~wr_hi_i),
      .wr_hi   (wr_sel_s[n] & wr_hi_i),
      .wr_data (wr_data_i),
      .cnt     (cnt_s[n]),
      .wrap    (wrap_s[n])
    );
  end

  // Inhibit mask register; takes effect for events from the next cycle on.
  always_ff @(posedge clk) begin
    if (rst) begin
      inh_r <= {NUM_CNT{1'b0}};
    end else if (inh_wr_i) begin
      inh_r <= inh_data_i;
    end else begin
      inh_r <= inh_r;
    end
  end

  // Read mux over the pre-update counter values (AND-OR select).
  always_comb begin
    rd_cnt_s      = {CNT_W{1'b0}};
    rd_in_range_s = (32'(rd_idx_i) < NUM_CNT);
    for (int n = 0; n < NUM_CNT; n++) begin
      rd_cnt_s = rd_cnt_s | ({CNT_W{rd_idx_i == IDX_W'(n)}} & cnt_s[n]);
    end
  end

  // Read port: lo read also snapshots the upper half; hi read returns the snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_r  <= {XLEN{1'b0}};
      rd_valid_r <= 1'b0;
      shadow_r   <= {HI_W{1'b0}};
    end else begin
      rd_valid_r <= rd_en_i;
      if (rd_en_i && !rd_in_range_s) begin
        rd_data_r <= {XLEN{1'b0}};
      end else if (rd_en_i && rd_hi_i) begin
        rd_data_r <= XLEN'(shadow_r);
      end else if (rd_en_i) begin
        rd_data_r <= rd_cnt_s[XLEN-1:0];
        shadow_r  <= rd_cnt_s[CNT_W-1:XLEN];
      end else begin
        rd_data_r <= rd_data_r;
      end
    end
  end

  assign inh_o      = inh_r;
  assign rd_data_o  = rd_data_r;
  assign rd_valid_o = rd_valid_r;

`ifdef PERF_CNT_OVF_IRQ_EN
  logic [NUM_CNT-1:0] ovf_r;

  // Sticky overflow flags; a new wrap beats a clear strobe in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_r <= {NUM_CNT{1'b0}};
    end else begin
      ovf_r <= wrap_s | (ovf_r & ~ovf_clr_i);
    end
  end

  assign ovf_o = ovf_r;
  assign irq_o = |(ovf_r & ovf_irq_en_i);
`else
  logic unused_ovf;
  assign unused_ovf = ^{wrap_s, ovf_clr_i, ovf_irq_en_i};
  assign ovf_o      = {NUM_CNT{1'b0}};
  assign irq_o      = 1'b0;
`endif

endmodule
